// File: rtl/parking_gate_ctrl.sv
// Shared entry/exit barrier sequencer with lot occupancy tracking and a
// two-digit multiplexed active-low 7-segment readout (free / occupied).
module parking_gate_ctrl #(
    parameter int CAPACITY     = 8,
    parameter int OPEN_TIMEOUT = 50000000,
    parameter int CLOSE_CYCLES = 25000000,
    parameter int REFRESH_DIV  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       car_passed,
    output logic       gate_open,
    output logic       dir_exit,
    output logic       full,
    output logic [3:0] occupancy,
    output logic [6:0] seg,
    output logic [7:0] an
);

    // One timer serves both the open window and the closed hold window.
    localparam int TIMER_MAX = (OPEN_TIMEOUT > CLOSE_CYCLES) ? OPEN_TIMEOUT : CLOSE_CYCLES;
    localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX + 1) : 1;
    localparam int SW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [3:0]    CAP4       = 4'(CAPACITY);

    localparam logic [7:0] AN_DIGIT0 = 8'b1111_1110;
    localparam logic [7:0] AN_DIGIT1 = 8'b1111_1101;
    localparam logic [6:0] SEG_ZERO  = 7'b100_0000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OPEN_ENTRY = 2'd1,
        OPEN_EXIT  = 2'd2,
        HOLD       = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [3:0]      occ_reg, occ_next;

    logic [SW-1:0]   scan_reg, scan_next;
    logic            digit_sel_reg, digit_sel_next;
    logic [7:0]      an_reg, an_next;
    logic [6:0]      seg_reg, seg_next;
    logic [3:0]      digit_val;

    // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit; blank otherwise.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign full      = (occ_reg == CAP4);
    assign occupancy = occ_reg;
    assign an        = an_reg;
    assign seg       = seg_reg;

    // Gate arbitration, open/hold timing and occupancy counting.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        occ_next   = occ_reg;
        gate_open  = 1'b0;
        dir_exit   = 1'b0;
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                // Exit wins so a full lot can always drain.
                if (exit_req && (occ_reg != 4'd0)) begin
                    state_next = OPEN_EXIT;
                end else if (entry_req && !full) begin
                    state_next = OPEN_ENTRY;
                end
            end
            OPEN_ENTRY, OPEN_EXIT: begin
                gate_open = 1'b1;
                dir_exit  = (state_reg == OPEN_EXIT);
                if (car_passed) begin
                    if (state_reg == OPEN_EXIT) begin
                        occ_next = (occ_reg != 4'd0) ? occ_reg - 4'd1 : occ_reg;
                    end else begin
                        occ_next = (occ_reg < CAP4) ? occ_reg + 4'd1 : occ_reg;
                    end
                    state_next = HOLD;
                    timer_next = '0;
                end else if (timer_reg == OPEN_LAST) begin
                    state_next = HOLD;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            HOLD: begin
                if (timer_reg == CLOSE_LAST) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // FSM, timer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            occ_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            occ_reg   <= occ_next;
        end
    end

    // Display scan: pick the digit for the coming period from the post-edge
    // occupancy so the readout never lags the counter.
    always_comb begin
        scan_next      = scan_reg + 1'b1;
        digit_sel_next = digit_sel_reg;
        if (scan_reg == SCAN_LAST) begin
            scan_next      = '0;
            digit_sel_next = ~digit_sel_reg;
        end
        digit_val = digit_sel_next ? occ_next : (CAP4 - occ_next);
        an_next   = digit_sel_next ? AN_DIGIT1 : AN_DIGIT0;
        seg_next  = seg_decode(digit_val);
    end

    // Display registers; an and seg always move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_reg      <= '0;
            digit_sel_reg <= 1'b0;
            an_reg        <= AN_DIGIT0;
            seg_reg       <= SEG_ZERO;
        end else begin
            scan_reg      <= scan_next;
            digit_sel_reg <= digit_sel_next;
            an_reg        <= an_next;
            seg_reg       <= seg_next;
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scenario bench for parking_gate_ctrl with small timing parameters.
module tb_parking_gate_ctrl;

    localparam int CAP  = 3;
    localparam int OTO  = 16;
    localparam int CLC  = 4;
    localparam int RDIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req;
    logic       exit_req;
    logic       car_passed;
    logic       gate_open;
    logic       dir_exit;
    logic       full;
    logic [3:0] occupancy;
    logic [6:0] seg;
    logic [7:0] an;

    int tests_run = 0;
    int failed    = 0;
    int occ_m     = 0;
    int exp_q[$];

    parking_gate_ctrl #(
        .CAPACITY(CAP), .OPEN_TIMEOUT(OTO), .CLOSE_CYCLES(CLC), .REFRESH_DIV(RDIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
        .car_passed(car_passed), .gate_open(gate_open), .dir_exit(dir_exit),
        .full(full), .occupancy(occupancy), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full gate cycle with a car passing; checks grant and count.
    task automatic do_pass(input bit ex);
        int exp_occ;
        int got;
        if (ex) exit_req = 1'b1; else entry_req = 1'b1;
        step();
        tests_run++;
        if (gate_open !== 1'b1 || dir_exit !== ex) begin
            failed++;
            $display("FAIL pass_grant: got open=%b dir=%b expected open=1 dir=%b", gate_open, dir_exit, ex);
        end
        exit_req  = 1'b0;
        entry_req = 1'b0;
        step();
        step();
        car_passed = 1'b1;
        exp_occ = ex ? ((occ_m > 0) ? occ_m - 1 : 0) : ((occ_m < CAP) ? occ_m + 1 : CAP);
        exp_q.push_back(exp_occ);
        occ_m = exp_occ;
        step();
        car_passed = 1'b0;
        got = exp_q.pop_front();
        tests_run++;
        if (occupancy !== 4'(got) || gate_open !== 1'b0) begin
            failed++;
            $display("FAIL pass_count: got occ=%0d open=%b expected occ=%0d open=0", occupancy, gate_open, got);
        end
        repeat (CLC) step();
    endtask

    // Waits for each digit in turn and checks its segment pattern.
    task automatic check_display(input int free_v, input int occ_v);
        int n;
        n = 0;
        while (an !== 8'hFE && n < 12) begin step(); n++; end
        tests_run++;
        if (an !== 8'hFE || seg !== ref_seg(free_v)) begin
            failed++;
            $display("FAIL disp_digit0: got an=%b seg=%b expected an=11111110 seg=%b", an, seg, ref_seg(free_v));
        end
        n = 0;
        while (an !== 8'hFD && n < 12) begin step(); n++; end
        tests_run++;
        if (an !== 8'hFD || seg !== ref_seg(occ_v)) begin
            failed++;
            $display("FAIL disp_digit1: got an=%b seg=%b expected an=11111101 seg=%b", an, seg, ref_seg(occ_v));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
        repeat (3) step();
        tests_run++;
        if (gate_open !== 1'b0 || dir_exit !== 1'b0 || occupancy !== 4'd0 || full !== 1'b0) begin
            failed++;
            $display("FAIL reset_ctrl: got open=%b dir=%b occ=%0d full=%b expected 0 0 0 0", gate_open, dir_exit, occupancy, full);
        end
        tests_run++;
        if (an !== 8'b11111110 || seg !== 7'b1000000) begin
            failed++;
            $display("FAIL reset_disp: got an=%b seg=%b expected 11111110 1000000", an, seg);
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (an !== 8'b11111110 || seg !== ref_seg(CAP)) begin
            failed++;
            $display("FAIL reset_release: got an=%b seg=%b expected 11111110 %b", an, seg, ref_seg(CAP));
        end
        // Reset in the middle of an open entry window.
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        tests_run++;
        if (gate_open !== 1'b1) begin
            failed++;
            $display("FAIL reset_pre_open: got open=%b expected 1", gate_open);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (gate_open !== 1'b0 || occupancy !== 4'd0 || an !== 8'b11111110 || seg !== 7'b1000000) begin
            failed++;
            $display("FAIL reset_async: got open=%b occ=%0d an=%b seg=%b expected 0 0 11111110 1000000", gate_open, occupancy, an, seg);
        end
        step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (an !== 8'b11111110 || seg !== ref_seg(CAP) || gate_open !== 1'b0) begin
            failed++;
            $display("FAIL reset_after: got an=%b seg=%b open=%b expected 11111110 %b 0", an, seg, gate_open, ref_seg(CAP));
        end
        occ_m = 0;
        exp_q.delete();
    endtask

    task automatic test_entry();
        int closed;
        int got;
        entry_req = 1'b1;
        step();
        tests_run++;
        if (gate_open !== 1'b1 || dir_exit !== 1'b0) begin
            failed++;
            $display("FAIL entry_grant: got open=%b dir=%b expected 1 0", gate_open, dir_exit);
        end
        entry_req = 1'b0;
        repeat (4) step();
        car_passed = 1'b1;
        exp_q.push_back(occ_m + 1);
        occ_m = occ_m + 1;
        step();
        car_passed = 1'b0;
        got = exp_q.pop_front();
        tests_run++;
        if (occupancy !== 4'(got)) begin
            failed++;
            $display("FAIL entry_count: got occ=%0d expected %0d", occupancy, got);
        end
        closed = 0;
        for (int i = 0; i < CLC; i++) begin
            if (gate_open === 1'b0) closed++;
            step();
        end
        tests_run++;
        if (closed != CLC) begin
            failed++;
            $display("FAIL entry_hold: got %0d closed cycles expected %0d", closed, CLC);
        end
        check_display(CAP - occ_m, occ_m);
    endtask

    task automatic test_fill_reject();
        int opened;
        do_pass(1'b0);
        do_pass(1'b0);
        tests_run++;
        if (full !== 1'b1 || occupancy !== 4'(CAP)) begin
            failed++;
            $display("FAIL fill_full: got full=%b occ=%0d expected 1 %0d", full, occupancy, CAP);
        end
        entry_req = 1'b1;
        opened = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (gate_open !== 1'b0) opened++;
        end
        entry_req = 1'b0;
        tests_run++;
        if (opened != 0) begin
            failed++;
            $display("FAIL fill_reject: got %0d open cycles expected 0", opened);
        end
        check_display(0, CAP);
    endtask

    task automatic test_priority_exit();
        int n;
        int got;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        step();
        tests_run++;
        if (gate_open !== 1'b1 || dir_exit !== 1'b1) begin
            failed++;
            $display("FAIL prio_exit_grant: got open=%b dir=%b expected 1 1", gate_open, dir_exit);
        end
        exit_req = 1'b0;
        step();
        step();
        car_passed = 1'b1;
        exp_q.push_back(occ_m - 1);
        occ_m = occ_m - 1;
        step();
        car_passed = 1'b0;
        got = exp_q.pop_front();
        tests_run++;
        if (occupancy !== 4'(got) || full !== 1'b0) begin
            failed++;
            $display("FAIL prio_exit_count: got occ=%0d full=%b expected %0d 0", occupancy, full, got);
        end
        n = 0;
        while (gate_open !== 1'b1 && n < 20) begin step(); n++; end
        tests_run++;
        if (gate_open !== 1'b1 || dir_exit !== 1'b0) begin
            failed++;
            $display("FAIL prio_next_entry: got open=%b dir=%b expected 1 0", gate_open, dir_exit);
        end
        entry_req = 1'b0;
        step();
        car_passed = 1'b1;
        exp_q.push_back(occ_m + 1);
        occ_m = occ_m + 1;
        step();
        car_passed = 1'b0;
        got = exp_q.pop_front();
        tests_run++;
        if (occupancy !== 4'(got)) begin
            failed++;
            $display("FAIL prio_entry_count: got occ=%0d expected %0d", occupancy, got);
        end
        repeat (CLC) step();
    endtask

    task automatic test_timeout();
        int n;
        do_pass(1'b1);
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        n = 0;
        while (gate_open === 1'b1 && n < 100) begin n++; step(); end
        tests_run++;
        if (n != OTO) begin
            failed++;
            $display("FAIL timeout_len: got %0d open cycles expected %0d", n, OTO);
        end
        tests_run++;
        if (occupancy !== 4'(occ_m)) begin
            failed++;
            $display("FAIL timeout_occ: got %0d expected %0d", occupancy, occ_m);
        end
        repeat (CLC) step();
    endtask

    task automatic test_spurious_empty();
        int opened;
        car_passed = 1'b1;
        step();
        car_passed = 1'b0;
        step();
        tests_run++;
        if (occupancy !== 4'(occ_m) || gate_open !== 1'b0) begin
            failed++;
            $display("FAIL spurious: got occ=%0d open=%b expected %0d 0", occupancy, gate_open, occ_m);
        end
        while (occ_m > 0) do_pass(1'b1);
        exit_req = 1'b1;
        opened = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gate_open !== 1'b0) opened++;
        end
        exit_req = 1'b0;
        tests_run++;
        if (opened != 0 || occupancy !== 4'd0) begin
            failed++;
            $display("FAIL empty_exit: got %0d open cycles occ=%0d expected 0 0", opened, occupancy);
        end
    endtask

    task automatic test_display_scan();
        logic [7:0] prev;
        logic [7:0] val;
        int n;
        int len;
        int bad_hi;
        prev = an;
        n = 0;
        while (an === prev && n < 12) begin step(); n++; end
        bad_hi = 0;
        for (int r = 0; r < 4; r++) begin
            val = an;
            len = 0;
            while (an === val && len < 20) begin
                if (an[7:2] !== 6'h3F) bad_hi++;
                step();
                len++;
            end
            tests_run++;
            if (len != RDIV || (val !== 8'hFE && val !== 8'hFD) || val === prev) begin
                failed++;
                $display("FAIL scan_run%0d: got an=%b len=%0d expected alternate digit len=%0d", r, val, len, RDIV);
            end
            prev = val;
        end
        tests_run++;
        if (bad_hi != 0) begin
            failed++;
            $display("FAIL scan_high: got %0d cycles with an[7:2]!=111111 expected 0", bad_hi);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_fill_reject();
        test_priority_exit();
        test_timeout();
        test_spurious_empty();
        test_display_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Sequences one shared barrier gate between an entry lane and an exit lane.
- Tracks lot occupancy and refuses entry when the lot is full.
- Drives a two-digit multiplexed active-low 7-segment display showing free slots and occupied slots.
- Sits between the lane sensors, the barrier actuator and the board display.

Parameters:
- CAPACITY, 8: number of slots; legal range 1..9.
- OPEN_TIMEOUT, 50000000: cycles the gate may stay open waiting for car_passed.
- CLOSE_CYCLES, 25000000: cycles the gate is held closed before the next grant.
- REFRESH_DIV, 100000: cycles each display digit is lit.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- entry_req  in  1  car waiting at the entry barrier; level signal.
- exit_req  in  1  car waiting at the exit barrier; level signal.
- car_passed  in  1  one-cycle pulse from the barrier loop when a car has passed.
- gate_open  out  1  barrier actuator; 1 = raised.
- dir_exit  out  1  valid while gate_open; 1 = exit grant, 0 = entry grant.
- full  out  1  occupancy == CAPACITY.
- occupancy  out  4  occupied slot count.
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  out  8  digit anodes, active-low.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = IDLE.
  - gate_open = 0, dir_exit = 0.
  - occupancy = 0, full = 0.
  - timer = 0, scan counter = 0, digit select = 0.
  - an = 8'b11111110, seg = 7'b1000000 (digit 0 showing "0").
- Reset asserted mid-operation drops the gate immediately, clears occupancy and returns to IDLE.
- FSM states: IDLE, OPEN_ENTRY, OPEN_EXIT, HOLD.
- IDLE:
  - If exit_req=1 and occupancy>0, go to OPEN_EXIT. Exit has priority over entry.
  - Else if entry_req=1 and full=0, go to OPEN_ENTRY.
  - Else stay in IDLE.
  - exit_req with occupancy==0 is ignored.
  - entry_req while full is ignored; the gate stays down.
- OPEN_ENTRY / OPEN_EXIT:
  - gate_open=1. dir_exit is 0 in OPEN_ENTRY and 1 in OPEN_EXIT.
  - The timer counts up from 0.
  - car_passed=1: occupancy +1 (entry) or -1 (exit), then go to HOLD.
  - The count is registered on the same edge as the state change, so occupancy updates one cycle after the pulse.
  - Timer reaching OPEN_TIMEOUT-1 without car_passed: go to HOLD with no count change.
  - If car_passed arrives on the timeout cycle, the pass is counted.
- HOLD:
  - gate_open=0.
  - Timer counts CLOSE_CYCLES cycles, then go to IDLE.
  - car_passed in HOLD or IDLE is ignored and produces no count change.
- Grant latency: gate_open rises on the first clk edge after a qualifying request is sampled in IDLE.
- Occupancy arithmetic:
  - Saturates at 0 and at CAPACITY; it never wraps.
  - full is combinational from the occupancy register.
- Requests held high through HOLD:
  - Re-arbitrate in IDLE with exit priority.
  - A continuously asserted exit_req can starve entry. This is accepted behaviour.
- Display:
  - Scan counter wraps at REFRESH_DIV-1. On each wrap, digit select toggles.
  - Digit 0: an=8'b11111110, shows CAPACITY-occupancy (free slots).
  - Digit 1: an=8'b11111101, shows occupancy.
  - Digits 2..7 are always off.
  - seg is registered with an; both change on the same edge.
- 7-segment decode, active-low, for values 0..9:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
- Any other value displays as blank, 1111111.

Test Plan:
Bench parameters: CAPACITY=3, OPEN_TIMEOUT=16, CLOSE_CYCLES=4, REFRESH_DIV=4.
- Reset: pulse rst_n low mid-cycle -> gate_open=0, occupancy=0, an=11111110 and seg=1000000 asynchronously; after release, digit 0 shows 3 (0110000) until the scan toggles.
- Entry: entry_req=1, then car_passed pulse 5 cycles later -> gate_open=1, dir_exit=0 the cycle after the request; occupancy=1 the cycle after the pulse; gate_open=0 for 4 cycles; digit 0 shows 2 and digit 1 shows 1.
- Fill and reject: three entry passes -> full=1, occupancy=3. A further entry_req for 40 cycles -> gate_open stays 0. Digit 0 seg=1000000, digit 1 seg=0110000.
- Priority and exit: entry_req=exit_req=1 in IDLE with occupancy=3 -> OPEN_EXIT with dir_exit=1. car_passed -> occupancy=2, full=0. Next grant is entry.
- Timeout: entry_req, no car_passed -> gate_open falls after exactly 16 open cycles; occupancy is unchanged.
- Spurious and empty: car_passed in IDLE -> no change. exit_req with occupancy=0 -> gate stays closed.
- Display scan: an alternates 11111110 and 11111101 every 4 cycles, and an[7:2] is always 1.
